mem_d_reader: RTL and testbench
===============================

MEM_D_READER -- requirements
Module: mem_d_reader

Interface
REQ-001 Parameter MAX_OUTSTANDING, default 4: maximum read requests in flight plus buffered responses; power of two, range 2..16.
REQ-002 Parameter TAG_W, default 11: width of the request and response tags.
REQ-003 clk_i  in  1  single clock; all logic on its rising edge.
REQ-004 rst_i  in  1  reset, asynchronous assert, active-low.
REQ-005 start_i  in  1  one-cycle pulse that launches a transfer; sampled only in IDLE.
REQ-006 base_addr_i  in  32  byte address of the first word; bits [1:0] are ignored and treated as 0.
REQ-007 count_i  in  16  number of 32-bit words to read; 0 is legal.
REQ-008 busy_o  out  1  high from the cycle after start until done_o.
REQ-009 done_o  out  1  one-cycle completion pulse.
REQ-010 error_o  out  1  sticky error flag; cleared on the next accepted start.
REQ-011 mem_d_addr_o  out  32  read address.
REQ-012 mem_d_rd_o  out  1  read request strobe.
REQ-013 mem_d_req_tag_o  out  TAG_W  request tag.
REQ-014 mem_d_wr_o  out  4  constant 0.
REQ-015 mem_d_data_wr_o  out  32  constant 0.
REQ-016 mem_d_cacheable_o, mem_d_invalidate_o, mem_d_writeback_o, mem_d_flush_o  out  1 each  constant 0.
REQ-017 mem_d_accept_i  in  1  request accepted this cycle.
REQ-018 mem_d_ack_i  in  1  read response valid.
REQ-019 mem_d_data_rd_i  in  32  read response data.
REQ-020 mem_d_error_i  in  1  read response error.
REQ-021 mem_d_resp_tag_i  in  TAG_W  read response tag.
REQ-022 data_valid_o  out  1  output word valid.
REQ-023 data_o  out  32  output word.
REQ-024 data_idx_o  out  16  word index within the transfer.
REQ-025 data_ready_i  in  1  consumer accepts the output word.

Function
REQ-026 FSM states SHALL be IDLE, ISSUE, DRAIN and DONE; start_i SHALL move IDLE to ISSUE, latching base, count, clearing error_o and zeroing the issue and receive counters.
REQ-027 Start with count_i=0 SHALL go directly to DONE, issue no request, and pulse done_o on the next cycle.
REQ-028 A request fires when mem_d_rd_o=1 and mem_d_accept_i=1 in the same cycle. Once raised, mem_d_rd_o with its address and tag SHALL remain stable until the request fires.
REQ-029 Request n SHALL use address = base + 4*n, modulo 2^32 (wraps past 0xFFFFFFFC), and tag = n[TAG_W-1:0].
REQ-030 mem_d_rd_o SHALL be asserted only when issued minus popped < MAX_OUTSTANDING, so every ack always has a buffer slot.
REQ-031 Responses arrive in order. Each ack SHALL be written to the response FIFO the same cycle with {data, error, index}; acks SHALL never be dropped.
REQ-032 A response whose mem_d_resp_tag_i differs from the expected receive count [TAG_W-1:0], or with mem_d_error_i=1, SHALL set error_o. The word SHALL still be delivered.
REQ-033 ISSUE SHALL go to DRAIN the cycle after the last request fires.
REQ-034 DRAIN SHALL go to DONE when all count responses have been received and the FIFO is empty.
REQ-035 DONE SHALL pulse done_o for one cycle, then return to IDLE.
REQ-036 data_valid_o SHALL equal FIFO not-empty; data_o and data_idx_o SHALL come from the FIFO head.
REQ-037 The FIFO SHALL pop on data_valid_o and data_ready_i; pop and push in the same cycle are legal when full.
REQ-038 start_i SHALL be ignored while busy_o=1 or done_o=1.
REQ-039 Output latency from ack to data_valid_o SHALL be 1 cycle.

Reset
REQ-040 Reset SHALL force IDLE and zero all counters and the FIFO pointers.
REQ-041 Reset SHALL drive busy_o, done_o, error_o, mem_d_rd_o and data_valid_o to 0, and mem_d_addr_o, mem_d_req_tag_o, data_o and data_idx_o to 0.
REQ-042 Reset mid-transfer SHALL abandon the transfer; acks arriving after reset deasserts while in IDLE SHALL be discarded and SHALL not set error_o.

Structure
REQ-043 Package mem_d_reader_pkg SHALL hold the FSM state enum, the address stride constant (4), and the response-entry struct {data[31:0], err, idx[15:0]}.
REQ-044 The response buffer SHALL be the sub-module mem_d_reader_fifo (synchronous, depth MAX_OUTSTANDING, registered read-data output).

Verification
REQ-045 Scenario: base=0x80004800, count=4, memory always accepts with 1-cycle ack, data_ready_i=1 -> addresses 0x80004800/04/08/0C, tags 0..3, outputs idx 0..3, one done_o pulse, error_o=0.
REQ-046 Scenario: count=0 -> no mem_d_rd_o assertion, done_o pulses 2 cycles after start, busy_o stays 0.
REQ-047 Scenario: count=10, data_ready_i=0 for 20 cycles -> mem_d_rd_o stops after 4 requests, no ack lost; after data_ready_i=1, idx 0..9 arrive in order.
REQ-048 Scenario: mem_d_accept_i=0 for 5 cycles on request 2 -> address 0x80004808 and tag 2 held stable throughout.
REQ-049 Scenario: response 1 has mem_d_error_i=1, or response tag 5 arrives when 1 is expected -> error_o=1 until the next start, and all words are still delivered.
REQ-050 Scenario: base=0xFFFFFFF8, count=3 -> addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000; rst_i low in mid-DRAIN -> all outputs 0 and IDLE on the next cycle.

Source files
------------

// File: rtl/mem_d_reader_pkg.sv
// Shared types and constants for the streaming data-memory reader.
package mem_d_reader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int unsigned ADDR_STRIDE = 4;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
    logic [15:0] idx;
  } resp_entry_t;

endpackage

// File: rtl/mem_d_reader_fifo.sv
// Response buffer: synchronous FIFO whose head entry is held in a register so
// a freshly pushed word into an empty buffer is visible one cycle later.
module mem_d_reader_fifo
  import mem_d_reader_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        push_i,
  input  resp_entry_t wdata_i,
  input  logic        pop_i,
  output logic        valid_o,
  output resp_entry_t rdata_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  resp_entry_t      mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] rd_ptr_nx;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nx;
  logic             pop;

  assign valid_o = (cnt != '0);
  assign pop     = pop_i && valid_o;

  always_comb begin
    rd_ptr_nx = rd_ptr + PTR_W'(pop);
    cnt_nx    = cnt + CNT_W'(push_i) - CNT_W'(pop);
  end

  always_ff @(posedge clk_i) begin
    if (push_i) mem[wr_ptr] <= wdata_i;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      cnt     <= '0;
      rdata_o <= '0;
    end else begin
      if (push_i) wr_ptr <= wr_ptr + PTR_W'(1);
      rd_ptr <= rd_ptr_nx;
      cnt    <= cnt_nx;
      // the pushed word becomes the head when nothing older survives this edge
      if (push_i && cnt_nx == CNT_W'(1)) rdata_o <= wdata_i;
      else if (cnt_nx != '0)             rdata_o <= mem[rd_ptr_nx];
    end
  end

endmodule

// File: rtl/mem_d_reader.sv
// Reads count_i consecutive 32-bit words over the data-memory port with
// bounded pipelining and streams them, in order, out of a response buffer.
//   state | meaning
//   IDLE  | waiting for start_i
//   ISSUE | issuing read requests, collecting responses
//   DRAIN | all requests issued, waiting for responses and buffer empty
//   DONE  | one-cycle completion, pulses done_o
module mem_d_reader
  import mem_d_reader_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4,
  parameter int TAG_W           = 11
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [31:0]      base_addr_i,
  input  logic [15:0]      count_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             error_o,
  output logic [31:0]      mem_d_addr_o,
  output logic             mem_d_rd_o,
  output logic [TAG_W-1:0] mem_d_req_tag_o,
  output logic [3:0]       mem_d_wr_o,
  output logic [31:0]      mem_d_data_wr_o,
  output logic             mem_d_cacheable_o,
  output logic             mem_d_invalidate_o,
  output logic             mem_d_writeback_o,
  output logic             mem_d_flush_o,
  input  logic             mem_d_accept_i,
  input  logic             mem_d_ack_i,
  input  logic [31:0]      mem_d_data_rd_i,
  input  logic             mem_d_error_i,
  input  logic [TAG_W-1:0] mem_d_resp_tag_i,
  output logic             data_valid_o,
  output logic [31:0]      data_o,
  output logic [15:0]      data_idx_o,
  input  logic             data_ready_i
);

  localparam int CNT_W = 17;

  state_t           state;
  logic [31:0]      base_q;
  logic [15:0]      count_q;
  logic [CNT_W-1:0] issued;
  logic [CNT_W-1:0] recv;
  logic [CNT_W-1:0] popped;
  logic [CNT_W-1:0] issued_nx;
  logic [CNT_W-1:0] popped_nx;
  logic             fire;
  logic             pop;
  logic             push;
  logic             can_issue;
  logic             resp_bad;
  resp_entry_t      push_entry;
  resp_entry_t      head;

  assign mem_d_wr_o         = 4'h0;
  assign mem_d_data_wr_o    = 32'h0;
  assign mem_d_cacheable_o  = 1'b0;
  assign mem_d_invalidate_o = 1'b0;
  assign mem_d_writeback_o  = 1'b0;
  assign mem_d_flush_o      = 1'b0;

  assign fire      = mem_d_rd_o && mem_d_accept_i;
  assign pop       = data_valid_o && data_ready_i;
  assign push      = mem_d_ack_i && (state == ISSUE || state == DRAIN);
  assign issued_nx = issued + CNT_W'(fire);
  assign popped_nx = popped + CNT_W'(pop);
  // in-flight plus buffered never exceeds the buffer depth, so acks always fit
  assign can_issue = (issued_nx < CNT_W'(count_q)) &&
                     ((issued_nx - popped_nx) < CNT_W'(MAX_OUTSTANDING));
  assign resp_bad  = mem_d_error_i || (mem_d_resp_tag_i != TAG_W'(recv));
  assign push_entry = '{data: mem_d_data_rd_i, err: resp_bad, idx: recv[15:0]};

  assign data_o     = head.data;
  assign data_idx_o = head.idx;

  mem_d_reader_fifo #(
    .DEPTH(MAX_OUTSTANDING)
  ) u_fifo (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .push_i (push),
    .wdata_i(push_entry),
    .pop_i  (pop),
    .valid_o(data_valid_o),
    .rdata_o(head)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state           <= IDLE;
      base_q          <= '0;
      count_q         <= '0;
      issued          <= '0;
      recv            <= '0;
      popped          <= '0;
      busy_o          <= 1'b0;
      done_o          <= 1'b0;
      error_o         <= 1'b0;
      mem_d_rd_o      <= 1'b0;
      mem_d_addr_o    <= '0;
      mem_d_req_tag_o <= '0;
    end else begin
      done_o <= 1'b0;
      issued <= issued_nx;
      popped <= popped_nx;
      if (push) begin
        recv <= recv + CNT_W'(1);
        if (resp_bad) error_o <= 1'b1;
      end
      if (pop && head.err) error_o <= 1'b1;

      case (state)
        IDLE: begin
          if (start_i && !done_o) begin
            base_q  <= base_addr_i & 32'hFFFF_FFFC;
            count_q <= count_i;
            error_o <= 1'b0;
            issued  <= '0;
            recv    <= '0;
            popped  <= '0;
            if (count_i == 16'd0) begin
              state <= DONE;
            end else begin
              state           <= ISSUE;
              busy_o          <= 1'b1;
              mem_d_rd_o      <= 1'b1;
              mem_d_addr_o    <= base_addr_i & 32'hFFFF_FFFC;
              mem_d_req_tag_o <= '0;
            end
          end
        end
        ISSUE: begin
          // address and tag only move once the current request has fired
          if (!mem_d_rd_o || fire) begin
            mem_d_rd_o <= can_issue;
            if (can_issue) begin
              mem_d_addr_o    <= base_q + 32'(issued_nx) * ADDR_STRIDE;
              mem_d_req_tag_o <= TAG_W'(issued_nx);
            end
          end
          if (fire && issued_nx == CNT_W'(count_q)) state <= DRAIN;
        end
        DRAIN: begin
          if (recv == CNT_W'(count_q) && !data_valid_o) state <= DONE;
        end
        DONE: begin
          done_o <= 1'b1;
          busy_o <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_d_reader.sv
// Bench for mem_d_reader: memory responder, consumer, and transfer-level
// reference expectations derived from base, count and injected faults.
module tb_mem_d_reader;

  localparam int TAG_W = 11;
  localparam int MAXO  = 4;

  logic             clk_i = 1'b0;
  logic             rst_i = 1'b0;
  logic             start_i = 1'b0;
  logic [31:0]      base_addr_i = '0;
  logic [15:0]      count_i = '0;
  logic             busy_o, done_o, error_o;
  logic [31:0]      mem_d_addr_o;
  logic             mem_d_rd_o;
  logic [TAG_W-1:0] mem_d_req_tag_o;
  logic [3:0]       mem_d_wr_o;
  logic [31:0]      mem_d_data_wr_o;
  logic             mem_d_cacheable_o, mem_d_invalidate_o, mem_d_writeback_o, mem_d_flush_o;
  logic             mem_d_accept_i = 1'b0;
  logic             mem_d_ack_i = 1'b0;
  logic [31:0]      mem_d_data_rd_i = '0;
  logic             mem_d_error_i = 1'b0;
  logic [TAG_W-1:0] mem_d_resp_tag_i = '0;
  logic             data_valid_o;
  logic [31:0]      data_o;
  logic [15:0]      data_idx_o;
  logic             data_ready_i = 1'b0;

  mem_d_reader #(.MAX_OUTSTANDING(MAXO), .TAG_W(TAG_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .base_addr_i(base_addr_i),
    .count_i(count_i), .busy_o(busy_o), .done_o(done_o), .error_o(error_o),
    .mem_d_addr_o(mem_d_addr_o), .mem_d_rd_o(mem_d_rd_o), .mem_d_req_tag_o(mem_d_req_tag_o),
    .mem_d_wr_o(mem_d_wr_o), .mem_d_data_wr_o(mem_d_data_wr_o),
    .mem_d_cacheable_o(mem_d_cacheable_o), .mem_d_invalidate_o(mem_d_invalidate_o),
    .mem_d_writeback_o(mem_d_writeback_o), .mem_d_flush_o(mem_d_flush_o),
    .mem_d_accept_i(mem_d_accept_i), .mem_d_ack_i(mem_d_ack_i),
    .mem_d_data_rd_i(mem_d_data_rd_i), .mem_d_error_i(mem_d_error_i),
    .mem_d_resp_tag_i(mem_d_resp_tag_i), .data_valid_o(data_valid_o), .data_o(data_o),
    .data_idx_o(data_idx_o), .data_ready_i(data_ready_i)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail = 0;

  // responder / consumer configuration
  int acc_pct = 100, rdy_pct = 100, lat_max = 1;
  int err_idx = -1, bad_idx = -1, stall_tag = -1, stall_left = 0;
  int ready_hold_until = 0;
  bit stray_ack = 0;

  // observation
  int cyc = 0, fires = 0, pops = 0, ridx = 0, done_seen = 0, rd_seen = 0, d0 = 0;
  logic [31:0]      f_addr[$];
  logic [TAG_W-1:0] f_tag[$];
  logic [15:0]      o_idx[$];
  logic [31:0]      o_data[$];
  logic [31:0]      pend_addr[$];
  logic [TAG_W-1:0] pend_tag[$];
  int               pend_due[$];
  bit               prev_rd = 0, prev_acc = 0;
  logic [31:0]      prev_addr = '0;
  logic [TAG_W-1:0] prev_tag = '0;

  function automatic logic [31:0] memword(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0F0F_1234;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic chk_true(input string name, input bit ok, input int act);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: value %0d outside allowed range", name, act);
    end
  endtask

  task automatic fail_timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  task automatic step();
    @(negedge clk_i);
    #1;
  endtask

  // memory responder and data consumer, acting on the falling edge
  always @(negedge clk_i) begin
    bit acc, rdy;
    cyc++;
    mem_d_ack_i   = 1'b0;
    mem_d_error_i = 1'b0;
    if (!rst_i) begin
      pend_addr.delete(); pend_tag.delete(); pend_due.delete();
      prev_rd = 0; mem_d_accept_i = 1'b0; data_ready_i = 1'b0;
    end else begin
      if (prev_rd && !prev_acc) begin
        chk("hold_rd", mem_d_rd_o, 1);
        chk("hold_addr", mem_d_addr_o, prev_addr);
        chk("hold_tag", mem_d_req_tag_o, prev_tag);
      end
      acc = ($urandom_range(99) < acc_pct);
      if (mem_d_rd_o && stall_left > 0 && int'(mem_d_req_tag_o) == stall_tag) begin
        acc = 0;
        stall_left--;
      end
      mem_d_accept_i = acc;
      if (mem_d_rd_o && acc) begin
        chk_true("outstanding", (fires - pops) < MAXO, fires - pops);
        f_addr.push_back(mem_d_addr_o);
        f_tag.push_back(mem_d_req_tag_o);
        pend_addr.push_back(mem_d_addr_o);
        pend_tag.push_back(mem_d_req_tag_o);
        pend_due.push_back(cyc + int'($urandom_range(1, lat_max)));
        fires++;
      end
      if (mem_d_rd_o) rd_seen++;
      prev_rd = mem_d_rd_o; prev_acc = acc; prev_addr = mem_d_addr_o; prev_tag = mem_d_req_tag_o;

      if (stray_ack) begin
        mem_d_ack_i = 1'b1; mem_d_error_i = 1'b1;
        mem_d_resp_tag_i = 11'd7; mem_d_data_rd_i = 32'hDEAD_BEEF;
        stray_ack = 0;
      end else if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
        mem_d_ack_i      = 1'b1;
        mem_d_data_rd_i  = memword(pend_addr[0]);
        mem_d_resp_tag_i = (ridx == bad_idx) ? 11'd5 : pend_tag[0];
        mem_d_error_i    = (ridx == err_idx);
        ridx++;
        void'(pend_addr.pop_front()); void'(pend_tag.pop_front()); void'(pend_due.pop_front());
      end

      rdy = (cyc >= ready_hold_until) && ($urandom_range(99) < rdy_pct);
      data_ready_i = rdy;
      if (data_valid_o && rdy) begin
        o_idx.push_back(data_idx_o);
        o_data.push_back(data_o);
        pops++;
      end
      if (done_o) done_seen++;
    end
  end

  task automatic check_zero(input string pfx);
    chk({pfx, "_busy"}, busy_o, 0);
    chk({pfx, "_done"}, done_o, 0);
    chk({pfx, "_error"}, error_o, 0);
    chk({pfx, "_rd"}, mem_d_rd_o, 0);
    chk({pfx, "_valid"}, data_valid_o, 0);
    chk({pfx, "_addr"}, mem_d_addr_o, 0);
    chk({pfx, "_tag"}, mem_d_req_tag_o, 0);
    chk({pfx, "_data"}, data_o, 0);
    chk({pfx, "_idx"}, data_idx_o, 0);
  endtask

  task automatic start_xfer(input logic [31:0] base, input int cnt);
    f_addr.delete(); f_tag.delete(); o_idx.delete(); o_data.delete();
    fires = 0; pops = 0; ridx = 0; d0 = done_seen;
    start_i = 1'b1; base_addr_i = base; count_i = 16'(cnt);
    step();
    start_i = 1'b0;
    chk("busy_after_start", busy_o, (cnt != 0) ? 1 : 0);
    chk("error_cleared", error_o, 0);
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && done_seen == d0; i++) step();
    if (done_seen == d0) fail_timeout("done");
  endtask

  task automatic check_xfer(input logic [31:0] base, input int cnt, input logic exp_err);
    logic [31:0] ab;
    ab = base & 32'hFFFF_FFFC;
    chk("req_count", fires, cnt);
    for (int n = 0; n < cnt && n < f_addr.size(); n++) begin
      chk("req_addr", f_addr[n], ab + 32'(n) * 32'd4);
      chk("req_tag", f_tag[n], n % (1 << TAG_W));
    end
    chk("out_count", o_idx.size(), cnt);
    for (int n = 0; n < cnt && n < o_idx.size(); n++) begin
      chk("out_idx", o_idx[n], n);
      chk("out_data", o_data[n], memword(ab + 32'(n) * 32'd4));
    end
    chk("error_flag", error_o, exp_err);
    step(); step();
    chk("done_pulses", done_seen - d0, 1);
    chk("busy_idle", busy_o, 0);
  endtask

  typedef struct {
    logic [31:0] base;
    int          cnt;
    int          acc;
    int          rdy;
    int          lat;
    int          err_at;
    int          bad_at;
    logic        exp_err;
    logic [31:0] exp_last;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{32'h8000_4800, 4, 100, 100, 1, -1, -1, 1'b0, 32'h8000_480C};
    vecs[1] = '{32'hFFFF_FFF8, 3, 100, 100, 1, -1, -1, 1'b0, 32'h0000_0000};
    vecs[2] = '{32'h1000_0003, 5,  50,  50, 2, -1, -1, 1'b0, 32'h1000_0010};
    vecs[3] = '{32'h8000_4800, 6, 100, 100, 1,  1, -1, 1'b1, 32'h8000_4814};
    vecs[4] = '{32'h8000_4800, 4, 100, 100, 1, -1,  1, 1'b1, 32'h8000_480C};
    vecs[5] = '{32'h2000_0000, 1,  70,  40, 3, -1, -1, 1'b0, 32'h2000_0000};

    repeat (3) step();
    check_zero("reset");
    chk("const_wr", mem_d_wr_o, 0);
    chk("const_wdata", mem_d_data_wr_o, 0);
    chk("const_flags", {mem_d_cacheable_o, mem_d_invalidate_o, mem_d_writeback_o, mem_d_flush_o}, 0);
    rst_i = 1'b1;
    repeat (2) step();

    for (int v = 0; v < 6; v++) begin
      acc_pct = vecs[v].acc; rdy_pct = vecs[v].rdy; lat_max = vecs[v].lat;
      err_idx = vecs[v].err_at; bad_idx = vecs[v].bad_at;
      start_xfer(vecs[v].base, vecs[v].cnt);
      wait_done(2000);
      if (f_addr.size() > 0) chk("last_addr", f_addr[$], vecs[v].exp_last);
      check_xfer(vecs[v].base, vecs[v].cnt, vecs[v].exp_err);
    end
    acc_pct = 100; rdy_pct = 100; lat_max = 1; err_idx = -1; bad_idx = -1;

    // zero-length transfer, plus a start offered while done_o is high
    begin
      int r0;
      r0 = rd_seen;
      start_xfer(32'h8000_4800, 0);
      chk("zero_done_early", done_o, 0);
      step();
      chk("zero_done_pulse", done_o, 1);
      chk("zero_busy", busy_o, 0);
      start_i = 1'b1; count_i = 16'd0;
      step();
      start_i = 1'b0;
      chk("zero_done_single", done_o, 0);
      repeat (3) step();
      chk("zero_done_count", done_seen - d0, 1);
      chk("zero_no_rd", rd_seen, r0);
    end

    // consumer stalled: request window fills, then everything drains in order
    ready_hold_until = cyc + 25;
    start_xfer(32'h8000_4800, 10);
    start_i = 1'b1; base_addr_i = 32'h1234_5670; count_i = 16'd2;
    step();
    start_i = 1'b0;
    repeat (18) step();
    chk("fires_at_limit", fires, MAXO);
    chk("rd_stalled", mem_d_rd_o, 0);
    chk("valid_held", data_valid_o, 1);
    wait_done(2000);
    check_xfer(32'h8000_4800, 10, 1'b0);

    // accept withheld on request 2
    stall_tag = 2; stall_left = 5;
    start_xfer(32'h8000_4800, 5);
    wait_done(2000);
    chk("stall_consumed", stall_left, 0);
    check_xfer(32'h8000_4800, 5, 1'b0);
    stall_tag = -1;

    // reset while draining, then a stray ack in IDLE
    ready_hold_until = cyc + 1000; err_idx = 0;
    start_xfer(32'h4000_0000, 3);
    repeat (12) step();
    chk("pre_reset_valid", data_valid_o, 1);
    chk("pre_reset_error", error_o, 1);
    rst_i = 1'b0;
    step();
    check_zero("mid_reset");
    rst_i = 1'b1; ready_hold_until = 0; err_idx = -1;
    step();
    stray_ack = 1;
    step(); step();
    chk("stray_error", error_o, 0);
    chk("stray_valid", data_valid_o, 0);

    for (int t = 0; t < 10; t++) begin
      logic [31:0] b;
      int c;
      logic ee;
      b = $urandom;
      if ($urandom_range(3) == 0) b = 32'hFFFF_FFC0 | (b & 32'h3F);
      c = $urandom_range(1, 20);
      acc_pct = $urandom_range(30, 100); rdy_pct = $urandom_range(30, 100);
      lat_max = $urandom_range(1, 3);
      err_idx = ($urandom_range(3) == 0) ? int'($urandom_range(0, c - 1)) : -1;
      bad_idx = ($urandom_range(3) == 0) ? int'($urandom_range(0, c - 1)) : -1;
      ee = (err_idx >= 0) || (bad_idx >= 0);
      start_xfer(b, c);
      wait_done(3000);
      check_xfer(b, c, ee);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
